// File: rtl/aes256_key_sched_pkg.sv
// Shared AES-256 key-schedule constants, FSM state type and the byte S-box table.
package aes256_key_sched_pkg;

  localparam int unsigned NK     = 8;
  localparam int unsigned NR     = 14;
  localparam int unsigned NWORDS = 60;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RK_W   = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    GEN  = 2'd2
  } state_t;

  // Byte x lives at bits [2047-8x -: 8], so row 0 (0x00..0x0f) is the top 128 bits.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes256_key_sched_sbox.sv
// Combinational word S-box (four byte S-boxes) and the rcon lookup used by the key schedule.
module aes_sbox_word
  import aes256_key_sched_pkg::*;
(
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

module aes_rcon
  import aes256_key_sched_pkg::*;
(
  input  logic [3:0]        idx,
  output logic [WORD_W-1:0] rcon
);

  logic [7:0] rc;

  always_comb begin
    rc = 8'h00;
    case (idx)
      4'd0: rc = 8'h01;
      4'd1: rc = 8'h02;
      4'd2: rc = 8'h04;
      4'd3: rc = 8'h08;
      4'd4: rc = 8'h10;
      4'd5: rc = 8'h20;
      4'd6: rc = 8'h40;
      4'd7: rc = 8'h80;
      4'd8: rc = 8'h1b;
      4'd9: rc = 8'h36;
      default: rc = 8'h00;
    endcase
  end

  assign rcon = {rc, 24'h000000};

endmodule

// File: rtl/aes256_key_sched.sv
// Sequential AES-256 key expansion: one word per GEN cycle, round keys handed out over valid/ready.
module aes256_key_sched
  import aes256_key_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [255:0]      key_in,
  output logic              ready,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [RK_W-1:0]   rk_data,
  output logic [3:0]        rk_idx,
  output logic              done
);

  state_t            state, state_d;
  logic [WORD_W-1:0] win [NK];
  logic [5:0]        widx;
  logic [1:0]        phase;
  logic              hs;
  logic              last;
  logic [WORD_W-1:0] rot_w, sub_in, sub_out, rcon_w, t_w, new_w;
  logic [3:0]        rcon_idx;

  assign ready    = (state == IDLE);
  assign rk_valid = (state == OUT);
  assign hs       = rk_valid & rk_ready;
  assign last     = (rk_idx == 4'(NR));
  assign rk_data  = (rk_idx == 4'd0) ? {win[0], win[1], win[2], win[3]}
                                     : {win[4], win[5], win[6], win[7]};

  // One S-box instance serves both the RotWord (i%8==0) and plain SubWord (i%8==4) steps.
  assign rot_w    = {win[7][23:0], win[7][31:24]};
  assign sub_in   = (widx[2:0] == 3'd0) ? rot_w : win[7];
  assign rcon_idx = {1'b0, widx[5:3]} - 4'd1;

  aes_sbox_word u_sbox (
    .din  (sub_in),
    .dout (sub_out)
  );

  aes_rcon u_rcon (
    .idx  (rcon_idx),
    .rcon (rcon_w)
  );

  always_comb begin
    t_w = win[7];
    case (widx[2:0])
      3'd0:    t_w = sub_out ^ rcon_w;
      3'd4:    t_w = sub_out;
      default: t_w = win[7];
    endcase
  end

  assign new_w = win[0] ^ t_w;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = OUT;
      OUT: begin
        if (hs) begin
          if (last)                  state_d = IDLE;
          else if (rk_idx != 4'd0)   state_d = GEN;
        end
      end
      GEN:     if (phase == 2'd3) state_d = OUT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NK; k++) win[k] <= '0;
      widx   <= 6'd8;
      rk_idx <= '0;
      phase  <= '0;
      done   <= 1'b0;
    end else begin
      done <= hs & last;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned k = 0; k < NK; k++) win[k] <= key_in[32*(7-k) +: 32];
            rk_idx <= '0;
            widx   <= 6'd8;
          end
        end
        OUT: begin
          if (hs && !last) begin
            rk_idx <= rk_idx + 4'd1;
            phase  <= '0;
          end
        end
        GEN: begin
          for (int unsigned k = 0; k < NK - 1; k++) win[k] <= win[k+1];
          win[NK-1] <= new_w;
          widx      <= widx + 6'd1;
          phase     <= phase + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_key_sched.sv
// Directed bench for aes256_key_sched with a cycle-level behavioural model and round-key scoreboard.
module tb_aes256_key_sched;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [255:0] key_in;
  logic         ready, rk_valid, done;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes256_key_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .ready    (ready),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
  } rk_t;

  localparam logic [255:0] KEY_A3  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A3_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] Z_RK2   = 128'h62636363626363636263636362636363;

  rk_t          q[$];
  logic [7:0]   sb [256];
  int           passed = 0, total = 0;
  logic         busy = 1'b0, exp_done = 1'b0;
  int           gap = 0;
  bit           mon_en = 1'b0, rand_ready = 1'b0;
  int           done_cnt = 0, done_cyc = 0, t0 = 0;
  int           hs_cyc [15];
  logic [127:0] got [15];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box derived from GF(2^8) inversion plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  task automatic push_run(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int j = 0; j < 8; j++) w[j] = k[255-32*j -: 32];
    for (int j = 8; j < 60; j++) begin
      t = w[j-1];
      if (j % 8 == 0) begin
        rc = 8'h01;
        for (int m = 1; m < j / 8; m++) rc = xt(rc);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
      end else if (j % 8 == 4) begin
        t = subw(t);
      end
      w[j] = w[j-8] ^ t;
    end
    for (int r = 0; r < 15; r++)
      q.push_back('{idx: 4'(r), data: {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}});
  endtask

  task automatic monitor();
    logic ev, nd;
    rk_t  e;
    ev = busy && (gap == 0);
    nd = 1'b0;
    chk("ready", 128'(ready), 128'(!busy));
    chk("rk_valid", 128'(rk_valid), 128'(ev));
    chk("done", 128'(done), 128'(exp_done));
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ev) begin
      if (q.size() == 0) chk("sb_underflow", 128'(q.size()), 128'd1);
      else begin
        chk("rk_idx", 128'(rk_idx), 128'(q[0].idx));
        chk("rk_data", rk_data, q[0].data);
      end
    end
    if (rst) begin
      busy = 1'b0;
      gap  = 0;
      q.delete();
    end else if (!busy && start) begin
      busy = 1'b1;
      gap  = 0;
      t0   = cyc;
      push_run(key_in);
    end else if (ev && rk_ready && q.size() != 0) begin
      e = q.pop_front();
      got[e.idx]    = rk_data;
      hs_cyc[e.idx] = cyc;
      if (e.idx == 4'd14) begin
        busy = 1'b0;
        nd   = 1'b1;
      end else if (e.idx == 4'd0) gap = 0;
      else gap = 4;
    end else if (gap > 0) begin
      gap--;
    end
    exp_done = nd;
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    #1;
    if (rand_ready) rk_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int bound, input string tag);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 128'(done_cnt - d0), 128'd1);
  endtask

  task automatic clear_hs();
    for (int k = 0; k < 15; k++) begin
      hs_cyc[k] = -1;
      got[k]    = '0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 128'(ready), 128'd1);
    chk({tag, "_valid"}, 128'(rk_valid), 128'd0);
    chk({tag, "_done"}, 128'(done), 128'd0);
    chk({tag, "_idx"}, 128'(rk_idx), 128'd0);
    chk({tag, "_data"}, rk_data, 128'd0);
  endtask

  initial begin
    int d0, d1, n;
    build_sbox();
    rst = 1'b1; start = 1'b0; rk_ready = 1'b1; key_in = '0;
    tick(); tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // FIPS-197 A.3 key, consumer always ready: exact latencies.
    clear_hs();
    key_in = KEY_A3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200, "run1_done");
    chk("a3_rk0", got[0], A3_RK0);
    chk("a3_rk2", got[2], A3_RK2);
    chk("a3_rk14", got[14], A3_RK14);
    chk("lat_rk0", 128'(hs_cyc[0] - t0), 128'd1);
    chk("lat_rk1", 128'(hs_cyc[1] - t0), 128'd2);
    chk("lat_rk2", 128'(hs_cyc[2] - t0), 128'd7);
    chk("lat_rk14", 128'(hs_cyc[14] - t0), 128'd67);
    chk("lat_done", 128'(done_cyc - t0), 128'd68);
    repeat (3) tick();

    // Random backpressure on the same key.
    clear_hs();
    d0 = done_cnt;
    rand_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3000, "rand_done");
    rand_ready = 1'b0;
    rk_ready = 1'b1;
    repeat (6) tick();
    chk("rand_rk0", got[0], A3_RK0);
    chk("rand_rk14", got[14], A3_RK14);
    chk("rand_single_done", 128'(done_cnt - d0), 128'd1);

    // start held high: ignored while busy, back-to-back restart on the done cycle.
    clear_hs();
    start = 1'b1;
    tick();
    wait_done(200, "held_done1");
    d1 = done_cyc;
    start = 1'b0;
    wait_done(200, "held_done2");
    chk("b2b_start", 128'(t0), 128'(d1));
    chk("b2b_rk14", got[14], A3_RK14);
    repeat (3) tick();

    // Reset in the middle of generating rk7.
    clear_hs();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (hs_cyc[6] < 0 && n < 100) begin
      tick();
      n++;
    end
    chk("reach_rk6", 128'(hs_cyc[6] >= 0), 128'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    d0 = done_cnt;
    repeat (8) tick();
    chk("midrst_no_done", 128'(done_cnt - d0), 128'd0);
    clear_hs();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200, "after_rst_done");
    chk("after_rst_lat0", 128'(hs_cyc[0] - t0), 128'd1);
    chk("after_rst_rk2", got[2], A3_RK2);
    repeat (3) tick();

    // All-zero key exercises rcon 0x01 and the RotWord/SubWord path at i=8.
    clear_hs();
    key_in = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200, "zero_done");
    chk("zero_rk0", got[0], 128'd0);
    chk("zero_rk2", got[2], Z_RK2);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
